// File: rtl/mem_stage.sv
// MEM pipeline stage: data memory with a fixed multi-cycle access latency.
// Instructions that do not touch memory pass straight through in one cycle.
// Loads and stores are latched, held for LATENCY edges, and then completed
// into the MEM/WB output registers with a one-cycle valid_out pulse.
module mem_stage #(
  parameter int MEM_WORDS = 64,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        WB_en_in,
  input  logic        MEM_R_EN_in,
  input  logic        MEM_W_EN_in,
  input  logic [31:0] PC_in,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] ST_val_in,
  input  logic [4:0]  Dest_in,
  output logic        ready_out,
  output logic        valid_out,
  output logic        WB_en,
  output logic        MEM_R_EN,
  output logic [31:0] PC,
  output logic [31:0] ALU_result,
  output logic [31:0] Mem_read_value,
  output logic [4:0]  Dest
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] LAT_M1 = CW'(LATENCY - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] cnt;

  logic          wb_q;
  logic          r_q;
  logic          w_q;
  logic [31:0]   pc_q;
  logic [31:0]   alu_q;
  logic [31:0]   st_q;
  logic [4:0]    dest_q;

  logic [31:0]   mem [MEM_WORDS];

  logic [AW-1:0] addr_q;
  logic          complete;

  assign addr_q    = alu_q[AW+1:2];
  assign complete  = (state == BUSY) && (cnt == '0);
  assign ready_out = (state == IDLE);

  // Data memory: written only when a latched store completes; never reset.
  always_ff @(posedge clk) begin
    if (rst && complete && w_q) begin
      mem[addr_q] <= st_q;
    end
  end

  // Control FSM, access latch and MEM/WB output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      cnt            <= '0;
      valid_out      <= 1'b0;
      WB_en          <= 1'b0;
      MEM_R_EN       <= 1'b0;
      PC             <= '0;
      ALU_result     <= '0;
      Mem_read_value <= '0;
      Dest           <= '0;
      wb_q           <= 1'b0;
      r_q            <= 1'b0;
      w_q            <= 1'b0;
      pc_q           <= '0;
      alu_q          <= '0;
      st_q           <= '0;
      dest_q         <= '0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            if (!MEM_R_EN_in && !MEM_W_EN_in) begin
              WB_en          <= WB_en_in;
              MEM_R_EN       <= MEM_R_EN_in;
              PC             <= PC_in;
              ALU_result     <= ALU_result_in;
              Mem_read_value <= '0;
              Dest           <= Dest_in;
              valid_out      <= 1'b1;
            end else begin
              wb_q   <= WB_en_in;
              r_q    <= MEM_R_EN_in;
              w_q    <= MEM_W_EN_in;
              pc_q   <= PC_in;
              alu_q  <= ALU_result_in;
              st_q   <= ST_val_in;
              dest_q <= Dest_in;
              cnt    <= LAT_M1;
              state  <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            WB_en          <= wb_q;
            MEM_R_EN       <= r_q;
            PC             <= pc_q;
            ALU_result     <= alu_q;
            Mem_read_value <= (r_q && !w_q) ? mem[addr_q] : '0;
            Dest           <= dest_q;
            valid_out      <= 1'b1;
            state          <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by random
// transactions, all checked against a word-array memory model.
module tb_mem_stage;

  localparam int MEM_WORDS = 64;
  localparam int LATENCY   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic        WB_en_in;
  logic        MEM_R_EN_in;
  logic        MEM_W_EN_in;
  logic [31:0] PC_in;
  logic [31:0] ALU_result_in;
  logic [31:0] ST_val_in;
  logic [4:0]  Dest_in;
  logic        ready_out;
  logic        valid_out;
  logic        WB_en;
  logic        MEM_R_EN;
  logic [31:0] PC;
  logic [31:0] ALU_result;
  logic [31:0] Mem_read_value;
  logic [4:0]  Dest;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [MEM_WORDS];
  logic        e_wb;
  logic        e_r;
  logic [31:0] e_pc;
  logic [31:0] e_alu;
  logic [31:0] e_rd;
  logic [4:0]  e_dest;

  mem_stage #(.MEM_WORDS(MEM_WORDS), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .WB_en_in(WB_en_in), .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
    .PC_in(PC_in), .ALU_result_in(ALU_result_in), .ST_val_in(ST_val_in),
    .Dest_in(Dest_in), .ready_out(ready_out), .valid_out(valid_out),
    .WB_en(WB_en), .MEM_R_EN(MEM_R_EN), .PC(PC), .ALU_result(ALU_result),
    .Mem_read_value(Mem_read_value), .Dest(Dest)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int wordOf(input logic [31:0] a);
    return int'((a >> 2) % MEM_WORDS);
  endfunction

  task automatic expectEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic exp_valid, input logic exp_ready);
    expectEq({tag, ".valid_out"}, {31'b0, valid_out}, {31'b0, exp_valid});
    expectEq({tag, ".ready_out"}, {31'b0, ready_out}, {31'b0, exp_ready});
    expectEq({tag, ".WB_en"}, {31'b0, WB_en}, {31'b0, e_wb});
    expectEq({tag, ".MEM_R_EN"}, {31'b0, MEM_R_EN}, {31'b0, e_r});
    expectEq({tag, ".PC"}, PC, e_pc);
    expectEq({tag, ".ALU_result"}, ALU_result, e_alu);
    expectEq({tag, ".Mem_read_value"}, Mem_read_value, e_rd);
    expectEq({tag, ".Dest"}, {27'b0, Dest}, {27'b0, e_dest});
  endtask

  task automatic idleInputs();
    valid_in    = 1'b0;
    WB_en_in    = 1'b0;
    MEM_R_EN_in = 1'b0;
    MEM_W_EN_in = 1'b0;
  endtask

  task automatic idleCycle(input string tag);
    idleInputs();
    @(negedge clk);
    checkOutput(tag, 1'b0, 1'b1);
  endtask

  // One instruction from acceptance to completion; optional junk during BUSY.
  task automatic applyStimulus(input string tag, input logic wb, input logic r, input logic w,
                               input logic [31:0] pc, input logic [31:0] alu,
                               input logic [31:0] st, input logic [4:0] dest, input bit stall);
    int          waitc;
    int          wi;
    logic [31:0] rd;
    bit          pass;
    waitc = 0;
    while (ready_out !== 1'b1 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    expectEq({tag, ".ready_wait"}, {31'b0, ready_out}, 32'd1);
    if (ready_out !== 1'b1) return;
    valid_in      = 1'b1;
    WB_en_in      = wb;
    MEM_R_EN_in   = r;
    MEM_W_EN_in   = w;
    PC_in         = pc;
    ALU_result_in = alu;
    ST_val_in     = st;
    Dest_in       = dest;
    wi   = wordOf(alu);
    rd   = (r && !w) ? model_mem[wi] : 32'h0;
    pass = !r && !w;
    @(negedge clk);
    if (!pass) begin
      repeat (LATENCY) begin
        checkOutput({tag, ".busy"}, 1'b0, 1'b0);
        if (stall) begin
          valid_in      = 1'b1;
          WB_en_in      = 1'($urandom);
          MEM_R_EN_in   = 1'($urandom);
          MEM_W_EN_in   = 1'($urandom);
          PC_in         = $urandom;
          ALU_result_in = 32'h99;
          ST_val_in     = $urandom;
          Dest_in       = 5'($urandom);
        end else begin
          idleInputs();
        end
        @(negedge clk);
      end
    end
    e_wb   = wb;
    e_r    = r;
    e_pc   = pc;
    e_alu  = alu;
    e_rd   = rd;
    e_dest = dest;
    if (w) model_mem[wi] = st;
    checkOutput({tag, ".done"}, 1'b1, 1'b1);
    idleInputs();
  endtask

  initial begin
    logic [31:0] old8;
    rst = 1'b0;
    idleInputs();
    PC_in = '0; ALU_result_in = '0; ST_val_in = '0; Dest_in = '0;
    e_wb = 0; e_r = 0; e_pc = 0; e_alu = 0; e_rd = 0; e_dest = 0;
    repeat (2) @(negedge clk);
    checkOutput("reset", 1'b0, 1'b1);
    rst = 1'b1;
    idleCycle("post_reset");

    // Fill every word so later loads have defined expectations.
    for (int i = 0; i < MEM_WORDS; i++) begin
      applyStimulus("init", 1'b0, 1'b0, 1'b1, $urandom, (32'(i) << 2) | ($urandom << 8),
                    $urandom, 5'($urandom), 1'b0);
    end

    applyStimulus("pass", 1'b1, 1'b0, 1'b0, 32'h10, 32'h55, 32'h0, 5'd7, 1'b0);
    idleCycle("pass_idle");

    applyStimulus("st20", 1'b0, 1'b0, 1'b1, 32'h20, 32'h20, 32'hDEADBEEF, 5'd1, 1'b0);
    applyStimulus("ld20", 1'b1, 1'b1, 1'b0, 32'h24, 32'h20, 32'h0, 5'd2, 1'b0);
    expectEq("ld20.value", Mem_read_value, 32'hDEADBEEF);

    applyStimulus("st104", 1'b0, 1'b0, 1'b1, 32'h30, 32'h104, 32'h1234, 5'd3, 1'b0);
    applyStimulus("ld007", 1'b1, 1'b1, 1'b0, 32'h34, 32'h007, 32'h0, 5'd4, 1'b0);
    expectEq("ld007.value", Mem_read_value, 32'h1234);
    applyStimulus("ld004", 1'b1, 1'b1, 1'b0, 32'h38, 32'h004, 32'h0, 5'd5, 1'b0);
    expectEq("ld004.value", Mem_read_value, 32'h1234);

    applyStimulus("stall_st", 1'b0, 1'b0, 1'b1, 32'h40, 32'h44, 32'hCAFE0001, 5'd6, 1'b1);
    applyStimulus("stall_ld", 1'b1, 1'b1, 1'b0, 32'h44, 32'h44, 32'h0, 5'd8, 1'b1);
    idleCycle("stall_idle");

    // Store accepted, then reset lands before its completion edge.
    old8 = model_mem[2];
    valid_in = 1'b1; WB_en_in = 1'b1; MEM_R_EN_in = 1'b0; MEM_W_EN_in = 1'b1;
    PC_in = 32'h50; ALU_result_in = 32'h08; ST_val_in = 32'hAAAA; Dest_in = 5'd9;
    @(negedge clk);
    checkOutput("rst_mid.busy", 1'b0, 1'b0);
    idleInputs();
    rst = 1'b0;
    @(negedge clk);
    e_wb = 0; e_r = 0; e_pc = 0; e_alu = 0; e_rd = 0; e_dest = 0;
    checkOutput("rst_mid.reset", 1'b0, 1'b1);
    rst = 1'b1;
    idleCycle("rst_mid.after");
    idleCycle("rst_mid.after2");
    applyStimulus("rst_mid.ld08", 1'b1, 1'b1, 1'b0, 32'h54, 32'h08, 32'h0, 5'd10, 1'b0);
    expectEq("rst_mid.ld08.value", Mem_read_value, old8);

    applyStimulus("both_rw", 1'b1, 1'b1, 1'b1, 32'h60, 32'h0C, 32'h77, 5'd11, 1'b0);
    applyStimulus("ld0C", 1'b1, 1'b1, 1'b0, 32'h64, 32'h0C, 32'h0, 5'd12, 1'b0);
    expectEq("ld0C.value", Mem_read_value, 32'h77);

    for (int i = 0; i < 6; i++) begin
      applyStimulus("b2b", 1'($urandom), 1'b0, 1'b0, $urandom, $urandom, $urandom,
                    5'($urandom), 1'b0);
    end
    idleCycle("b2b_idle");

    for (int i = 0; i < 200; i++) begin
      applyStimulus("rand", 1'($urandom), 1'($urandom), 1'($urandom), $urandom,
                    ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255)),
                    $urandom, 5'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idleCycle("rand_idle");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter MEM_WORDS, default 64, number of 32-bit data-memory words; power of two, at least 2.
REQ-002 Parameter LATENCY, default 2, clock edges from acceptance to completion of a memory access; at least 1.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-low.
REQ-005 Port valid_in  input  1  EXE/MEM register holds a valid instruction.
REQ-006 Port WB_en_in, MEM_R_EN_in, MEM_W_EN_in  input  1 each  control bits from EXE/MEM.
REQ-007 Port PC_in, ALU_result_in, ST_val_in  input  32 each  PC, address or ALU value, store data.
REQ-008 Port Dest_in  input  5  destination register index.
REQ-009 Port ready_out  output  1  stage can accept an instruction this cycle.
REQ-010 Port valid_out  output  1  MEM/WB outputs updated this cycle; one-cycle pulse.
REQ-011 Port WB_en, MEM_R_EN  output  1 each  registered control bits for WB.
REQ-012 Port PC, ALU_result, Mem_read_value  output  32 each  registered PC, ALU value, load data.
REQ-013 Port Dest  output  5  registered destination index.

Function
REQ-014 Internal memory SHALL be MEM_WORDS x 32 bits; word address = ALU_result_in[log2(MEM_WORDS)+1:2]; bits [1:0] and upper bits ignored, so out-of-range addresses wrap.
REQ-015 States SHALL be IDLE and BUSY; ready_out = 1 exactly in IDLE (combinational from state).
REQ-016 IDLE, valid_in=1, MEM_R_EN_in=0, MEM_W_EN_in=0: on that edge, outputs load from inputs, Mem_read_value=0, valid_out=1 next cycle, stay IDLE (zero-wait pass-through).
REQ-017 IDLE, valid_in=1, either memory enable set: on that edge, latch all inputs, load wait counter with LATENCY-1, enter BUSY; outputs unchanged.
REQ-018 BUSY, counter non-zero: decrement; inputs ignored.
REQ-019 BUSY, counter zero: on that edge perform access, load outputs from latched values, pulse valid_out, return to IDLE; completion edge = acceptance edge + LATENCY.
REQ-020 Read: Mem_read_value = memory word at latched address, read at the completion edge.
REQ-021 Write: word at latched address = latched ST_val at the completion edge; Mem_read_value = 0.
REQ-022 Both enables set: write only; Mem_read_value = 0; MEM_R_EN output = latched value.
REQ-023 A read on the cycle after a write completes to the same address SHALL return the new data.
REQ-024 valid_out is high only the cycle after a completion or pass-through edge; all other outputs hold their values between updates.
REQ-025 IDLE with valid_in=0: no state or output change except valid_out=0.
REQ-026 Back-to-back pass-throughs SHALL be accepted every cycle with no bubble.

Reset
REQ-027 rst=0 at a rising edge: state IDLE, counter 0, valid_out, WB_en, MEM_R_EN = 0; PC, ALU_result, Mem_read_value = 0; Dest = 0.
REQ-028 Reset while BUSY SHALL abort the access: no memory write, no valid_out pulse.
REQ-029 Memory contents SHALL NOT be reset; ready_out = 1 the cycle after reset deasserts.

Verification (LATENCY=2, MEM_WORDS=64)
REQ-030 Pass-through: valid_in, WB_en_in=1, ALU_result_in=0x55, Dest_in=7, PC_in=0x10 -> next cycle valid_out=1, ALU_result=0x55, Dest=7, PC=0x10, ready_out stays 1.
REQ-031 Store then load: write ST_val 0xDEADBEEF to address 0x20 -> ready_out low 2 cycles, valid_out at edge+2, Mem_read_value=0; then read 0x20 -> Mem_read_value=0xDEADBEEF, MEM_R_EN=1.
REQ-032 Wrap/alignment: write 0x1234 at address 0x104; read at 0x007 (word 1) and 0x004 -> both return 0x1234.
REQ-033 Stall: during BUSY drive valid_in with ALU_result_in=0x99 -> ignored; no extra valid_out; outputs reflect only the accepted instruction.
REQ-034 Reset mid-access: accept write 0xAAAA to 0x08, assert rst one cycle later -> all outputs 0, no valid_out; later read of 0x08 returns prior contents, not 0xAAAA.
REQ-035 Both enables: R=W=1, ST_val 0x77 to 0x0C -> Mem_read_value=0, later read of 0x0C returns 0x77.
